// File: rtl/qspi_sram_controller.sv
// qspi_sram_controller: single-byte quad-I/O (1S-4S-4S) read/write master for an external QSPI SRAM
`timescale 1ns/1ps
module qspi_sram_controller #(
    parameter logic [7:0] CMD_READ     = 8'hEB,
    parameter logic [7:0] CMD_WRITE    = 8'h38,
    parameter int         WAIT_CYCLES  = 6,
    parameter int         CS_HIGH_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        sck,
    output logic        ss_n,
    output logic [3:0]  sio_out,
    output logic [3:0]  sio_oe,
    input  logic [3:0]  sio_in
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] ADDR  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;
    localparam logic [2:0] WDATA = 3'd5;
    localparam logic [2:0] DESEL = 3'd6;
    localparam int WCW = $clog2(WAIT_CYCLES + 1);

    logic [2:0]     st, nst;
    logic           ph, wr, last;
    logic [3:0]     cnt, ncnt, dout, doe, wd;
    logic [WCW-1:0] wcnt;
    logic [23:0]    addr, addr_sh;
    logic [7:0]     wdata, rbuf, op_sh;

    always_comb begin
        last = st == CMD ? cnt == 4'd7 :
               st == ADDR ? cnt == 4'd5 :
               st == WAIT ? wcnt == WCW'(WAIT_CYCLES - 1) : cnt == 4'd1;
        nst = !last ? st :
              st == CMD ? ADDR :
              st == ADDR ? (wr ? WDATA : WAIT) :
              st == WAIT ? RDATA : DESEL;
        ncnt = last ? 4'd0 : cnt + 4'd1;
        op_sh = (wr ? CMD_WRITE : CMD_READ) << ncnt;
        addr_sh = addr << {ncnt, 2'b00};
        wd = ncnt[0] ? wdata[3:0] : wdata[7:4];
        dout = nst == CMD ? {3'b000, op_sh[7]} :
               nst == ADDR ? addr_sh[23:20] :
               nst == WDATA ? wd : 4'b0000;
        doe = nst == CMD ? 4'b0001 : (nst == ADDR || nst == WDATA) ? 4'b1111 : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            ph <= 1'b0;
            cnt <= 4'd0;
            wcnt <= '0;
            wr <= 1'b0;
            addr <= 24'd0;
            wdata <= 8'd0;
            rbuf <= 8'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            sck <= 1'b0;
            ss_n <= 1'b1;
            sio_out <= 4'd0;
            sio_oe <= 4'd0;
        end else begin
            rsp_valid <= 1'b0;
            if (st == IDLE) begin
                if (req_valid && req_ready) begin
                    wr <= req_write;
                    addr <= req_addr;
                    wdata <= req_wdata;
                    req_ready <= 1'b0;
                    st <= CMD;
                    ph <= 1'b1;
                    cnt <= 4'hF;
                end
            end else if (st == DESEL) begin
                if (cnt == 4'(CS_HIGH_CLKS - 1)) begin
                    st <= IDLE;
                    req_ready <= 1'b1;
                end
                cnt <= cnt + 4'd1;
            end else if (!ph) begin
                sck <= 1'b1;
                ph <= 1'b1;
                if (st == RDATA) rbuf <= cnt[0] ? {rbuf[7:4], sio_in} : {sio_in, rbuf[3:0]};
            end else begin
                sck <= 1'b0;
                ph <= 1'b0;
                st <= nst;
                cnt <= ncnt;
                wcnt <= st == WAIT ? wcnt + 1'b1 : '0;
                sio_out <= dout;
                sio_oe <= doe;
                ss_n <= nst == DESEL;
                if (nst == DESEL) begin
                    rsp_valid <= 1'b1;
                    if (!wr) rsp_rdata <= rbuf;
                end
            end
        end
    end
endmodule

// File: tb/tb_qspi_sram_controller.sv
// tb_qspi_sram_controller: random and directed transactions against a cycle-level reference model and a QSPI SRAM model
`timescale 1ns/1ps
module tb_qspi_sram_controller;
    localparam int W = 6;
    localparam int C = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = 24'd0;
    logic [7:0]  req_wdata = 8'd0;
    logic        req_ready, rsp_valid, sck, ss_n;
    logic [7:0]  rsp_rdata;
    logic [3:0]  sio_out, sio_oe;
    logic [3:0]  sio_in = 4'd0;

    qspi_sram_controller #(
        .CMD_READ(8'hEB), .CMD_WRITE(8'h38), .WAIT_CYCLES(W), .CS_HIGH_CLKS(C)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sck(sck), .ss_n(ss_n),
        .sio_out(sio_out), .sio_oe(sio_oe), .sio_in(sio_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM model: decodes the serial stream on sck rises, drives read nibbles after sck falls
    logic [7:0]  sram [int];
    int          rises = 0;
    bit          prev_sck = 1'b0;
    logic [7:0]  s_op = 8'd0, s_d = 8'd0, s_rd;
    logic [23:0] s_a = 24'd0;

    always @(negedge clk) begin
        if (ss_n) begin
            rises = 0;
            prev_sck = 1'b0;
            sio_in = 4'h0;
        end else begin
            if (sck && !prev_sck) begin
                if (rises < 8) s_op = {s_op[6:0], sio_out[0]};
                else if (rises < 14) s_a = {s_a[19:0], sio_out};
                else if (s_op == 8'h38 && rises < 16) begin
                    s_d = {s_d[3:0], sio_out};
                    if (rises == 15) sram[int'(s_a)] = s_d;
                end
                rises++;
            end
            prev_sck = sck;
            s_rd = sram.exists(int'(s_a)) ? sram[int'(s_a)] : 8'h00;
            if (s_op == 8'hEB && rises >= 14 + W) sio_in = rises == 14 + W ? s_rd[7:4] : s_rd[3:0];
        end
    end

    // Reference model: k counts clk edges since the accept edge
    bit          busy = 1'b0;
    int          k = 0, endk = 0;
    bit          m_w = 1'b0;
    logic [23:0] m_a = 24'd0;
    logic [7:0]  m_d = 8'd0, m_last = 8'd0;
    logic [7:0]  mem [int];
    int          d_acc = 0, d_rsp = 0, hi_run = 0;
    int          gaps[$];

    always @(posedge clk) begin
        bit          v, r, w, act;
        logic [23:0] a;
        logic [7:0]  d, op;
        logic [3:0]  e_sio, e_oe;
        int          p;
        r = rst; v = req_valid; w = req_write; a = req_addr; d = req_wdata;
        if (v && req_ready && !r) d_acc++;
        if (r) begin
            busy = 1'b0;
            m_last = 8'h00;
        end else if (!busy) begin
            if (v) begin
                busy = 1'b1; k = 0; m_w = w; m_a = a; m_d = d;
                endk = w ? 1 + 2 * 16 : 1 + 2 * (16 + W);
            end
        end else begin
            k++;
            if (k == endk) begin
                if (m_w) mem[int'(m_a)] = m_d;
                else m_last = mem.exists(int'(m_a)) ? mem[int'(m_a)] : 8'h00;
            end
            if (k == endk + C) busy = 1'b0;
        end
        #1;
        act = busy && k >= 1 && k < endk;
        p = (k - 1) / 2;
        op = m_w ? 8'h38 : 8'hEB;
        e_sio = 4'h0;
        e_oe = 4'h0;
        if (act) begin
            if (p < 8) begin
                e_sio = {3'b000, 1'(op >> (7 - p))};
                e_oe = 4'b0001;
            end else if (p < 14) begin
                e_sio = 4'(m_a >> (4 * (13 - p)));
                e_oe = 4'hF;
            end else if (m_w) begin
                e_sio = p == 14 ? m_d[7:4] : m_d[3:0];
                e_oe = 4'hF;
            end
        end
        if (rsp_valid) d_rsp++;
        if (ss_n) hi_run++;
        else begin
            if (hi_run > 0) gaps.push_back(hi_run);
            hi_run = 0;
        end
        chk("ss_n", 32'(ss_n), 32'(!act));
        chk("sck", 32'(sck), 32'(act && k % 2 == 0));
        chk("sio_out", 32'(sio_out), 32'(e_sio));
        chk("sio_oe", 32'(sio_oe), 32'(e_oe));
        chk("req_ready", 32'(req_ready), 32'(!busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(busy && k == endk));
        if (!busy || k >= endk || m_w) chk("rsp_rdata", 32'(rsp_rdata), 32'(m_last));
    end

    task automatic wait_accept(output bit ok);
        bit r;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            r = req_ready;
            @(posedge clk);
            ok = r;
            if (!ok) @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input bit w, input logic [23:0] a, input logic [7:0] d, input bit meddle,
                       output int lat, output logic [7:0] rd);
        bit ok;
        lat = -1;
        rd = 8'h00;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        wait_accept(ok);
        @(negedge clk);
        req_valid = 1'b0;
        if (!ok) return;
        for (int i = 1; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = i;
                rd = rsp_rdata;
                break;
            end
            if (meddle) begin
                req_valid = i < 10 && i[0];
                req_write = ~req_write;
                req_addr = 24'($urandom);
                req_wdata = 8'($urandom);
            end
        end
        req_valid = 1'b0;
        if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        int          lat, a0, r0, ng;
        logic [7:0]  rd;
        bit          ok;
        logic [23:0] pool [4];
        pool[0] = 24'hFFFFFF; pool[1] = 24'h000000; pool[2] = 24'h123456; pool[3] = 24'h00ABCD;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ss_n", 32'(ss_n), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_sio_oe", 32'(sio_oe), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b1, 24'h000123, 8'hA5, 1'b0, lat, rd);
        chk("wr_latency", 32'(lat), 32'd33);
        chk("wr_opcode", 32'(s_op), 32'h38);
        txn(1'b0, 24'h000123, 8'h00, 1'b0, lat, rd);
        chk("rd_latency", 32'(lat), 32'd45);
        chk("rd_opcode", 32'(s_op), 32'hEB);
        chk("rd_data", 32'(rd), 32'hA5);
        txn(1'b1, 24'hFFFFFF, 8'h3C, 1'b0, lat, rd);
        txn(1'b1, 24'h000000, 8'hC3, 1'b0, lat, rd);
        txn(1'b0, 24'hFFFFFF, 8'h00, 1'b0, lat, rd);
        chk("rd_top", 32'(rd), 32'h3C);
        txn(1'b0, 24'h000000, 8'h00, 1'b0, lat, rd);
        chk("rd_bottom", 32'(rd), 32'hC3);
        a0 = d_acc; r0 = d_rsp; ng = gaps.size();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 24'h000200; req_wdata = 8'h50;
        for (int j = 0; j < 3; j++) begin
            wait_accept(ok);
            @(negedge clk);
            req_addr = 24'(24'h000201 + j);
            req_wdata = 8'(8'h51 + j);
            if (j == 2) req_valid = 1'b0;
        end
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
        chk("b2b_idle", 32'(req_ready), 32'd1);
        chk("b2b_accepts", 32'(d_acc - a0), 32'd3);
        chk("b2b_rsps", 32'(d_rsp - r0), 32'd3);
        chk("b2b_gaps", 32'(gaps.size() - ng), 32'd3);
        if (gaps.size() >= 2) begin
            chk("b2b_gap2", 32'(gaps[gaps.size() - 1] >= C), 32'd1);
            chk("b2b_gap1", 32'(gaps[gaps.size() - 2] >= C), 32'd1);
        end
        txn(1'b0, 24'h000202, 8'h00, 1'b0, lat, rd);
        chk("b2b_rd", 32'(rd), 32'h52);
        txn(1'b1, 24'h000300, 8'h77, 1'b1, lat, rd);
        txn(1'b0, 24'h000300, 8'h00, 1'b0, lat, rd);
        chk("ignore_rd", 32'(rd), 32'h77);
        txn(1'b1, 24'h000010, 8'h11, 1'b0, lat, rd);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 24'h000010; req_wdata = 8'h22;
        wait_accept(ok);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (19) @(negedge clk);
        r0 = d_rsp;
        rst = 1'b1;
        #1;
        chk("abort_ss_n", 32'(ss_n), 32'd1);
        chk("abort_sck", 32'(sck), 32'd0);
        chk("abort_sio_oe", 32'(sio_oe), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_rsp", 32'(d_rsp - r0), 32'd0);
        txn(1'b0, 24'h000010, 8'h00, 1'b0, lat, rd);
        chk("abort_rd", 32'(rd), 32'h11);
        repeat (40) begin
            txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], 8'($urandom), 1'b0, lat, rd);
            if (lat < 0) break;
        end
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
